// File: rtl/tile_layers_if.sv
// tile_layers_if: host bus for tile maps, tile sets, palette and scroll registers
interface tile_layers_if #(
    parameter int LAYERS        = 2,
    parameter int TILE_BITS     = 5,
    parameter int MAP_COLS_BITS = 6,
    parameter int MAP_ROWS_BITS = 4,
    parameter int TILES_BITS    = 4,
    parameter int COLOR_BITS    = 4
);
    localparam int XW  = MAP_COLS_BITS + TILE_BITS;
    localparam int YW  = MAP_ROWS_BITS + TILE_BITS;
    localparam int TMA = MAP_ROWS_BITS + MAP_COLS_BITS;
    localparam int TSA = TILES_BITS + 2 * TILE_BITS;
    localparam int LW  = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    logic [LW-1:0]         host_layer;
    logic [TMA-1:0]        tm_address;
    logic                  tm_we;
    logic [TILES_BITS-1:0] tm_din;
    logic [TILES_BITS-1:0] tm_dout;
    logic [TSA-1:0]        ts_address;
    logic                  ts_we;
    logic [COLOR_BITS-1:0] ts_din;
    logic [COLOR_BITS-1:0] ts_dout;
    logic [COLOR_BITS-1:0] palette_address;
    logic                  palette_we;
    logic [23:0]           palette_din;
    logic [23:0]           palette_dout;
    logic                  scroll_we;
    logic [XW-1:0]         scroll_x_din;
    logic [YW-1:0]         scroll_y_din;
    modport master (
        output host_layer, tm_address, tm_we, tm_din, ts_address, ts_we, ts_din,
               palette_address, palette_we, palette_din, scroll_we, scroll_x_din, scroll_y_din,
        input  tm_dout, ts_dout, palette_dout
    );
    modport slave (
        input  host_layer, tm_address, tm_we, tm_din, ts_address, ts_we, ts_din,
               palette_address, palette_we, palette_din, scroll_we, scroll_x_din, scroll_y_din,
        output tm_dout, ts_dout, palette_dout
    );
endinterface

// File: rtl/tile_layers.sv
// tile_layers: composites LAYERS scrolled tile planes into palette RGB; TILE_LAYERS_VSYNC_LATCH_EN enables tear-free scroll commit at vsync
module tile_layers #(
    parameter int LAYERS        = 2,
    parameter int TILE_BITS     = 5,
    parameter int MAP_COLS_BITS = 6,
    parameter int MAP_ROWS_BITS = 4,
    parameter int TILES_BITS    = 4,
    parameter int COLOR_BITS    = 4
) (
    input  logic              VGA_CLK,
    input  logic              VGA_RESET,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              blank_n_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic [LAYERS-1:0] layer_enable,
    tile_layers_if.slave      host,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_n
);
    localparam int XW  = MAP_COLS_BITS + TILE_BITS;
    localparam int YW  = MAP_ROWS_BITS + TILE_BITS;
    localparam int TMA = MAP_ROWS_BITS + MAP_COLS_BITS;
    localparam int TSA = TILES_BITS + 2 * TILE_BITS;

    logic [TILES_BITS-1:0]  tm_mem [LAYERS][2**TMA];
    logic [COLOR_BITS-1:0]  ts_mem [LAYERS][2**TSA];
    logic [23:0]            pal [2**COLOR_BITS];
    logic [XW-1:0]          sx [LAYERS];
    logic [YW-1:0]          sy [LAYERS];
    logic [XW-1:0]          ex [LAYERS];
    logic [YW-1:0]          ey [LAYERS];
    logic [TILES_BITS-1:0]  tile [LAYERS];
    logic [2*TILE_BITS-1:0] fine [LAYERS];
    logic [COLOR_BITS-1:0]  pix [LAYERS];
    logic [COLOR_BITS-1:0]  cidx;
    logic [2:0]             vld;
    logic [3:0]             hs_d, vs_d, bl_d;
    logic [23:0]            rgb;
    logic                   hl_ok;

    assign hl_ok = 32'(host.host_layer) < LAYERS;

    // host writes land in the selected layer's memories and the shared palette; contents survive reset
    always_ff @(posedge VGA_CLK) begin
        if (host.tm_we && hl_ok) tm_mem[host.host_layer][host.tm_address] <= host.tm_din;
        if (host.ts_we && hl_ok) ts_mem[host.host_layer][host.ts_address] <= host.ts_din;
        if (host.palette_we) pal[host.palette_address] <= host.palette_din;
    end

    // registered host reads return pre-write data; an out-of-range layer reads as 0
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RESET) begin
            host.tm_dout      <= '0;
            host.ts_dout      <= '0;
            host.palette_dout <= '0;
        end else begin
            host.tm_dout      <= hl_ok ? tm_mem[host.host_layer][host.tm_address] : '0;
            host.ts_dout      <= hl_ok ? ts_mem[host.host_layer][host.ts_address] : '0;
            host.palette_dout <= pal[host.palette_address];
        end
    end

`ifdef TILE_LAYERS_VSYNC_LATCH_EN
    logic [XW-1:0] shx [LAYERS];
    logic [YW-1:0] shy [LAYERS];
    logic          vs_prev;

    // host loads shadows; every layer commits together on the vsync falling edge
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RESET) begin
            vs_prev <= 1'b1;
            for (int l = 0; l < LAYERS; l++) begin
                sx[l]  <= '0;
                sy[l]  <= '0;
                shx[l] <= '0;
                shy[l] <= '0;
            end
        end else begin
            vs_prev <= vs_in;
            for (int l = 0; l < LAYERS; l++) begin
                if (vs_prev && !vs_in) begin
                    sx[l] <= shx[l];
                    sy[l] <= shy[l];
                end
                if (host.scroll_we && 32'(host.host_layer) == l) begin
                    shx[l] <= host.scroll_x_din;
                    shy[l] <= host.scroll_y_din;
                end
            end
        end
    end
`else
    // host writes the live scroll registers directly
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RESET) begin
            for (int l = 0; l < LAYERS; l++) begin
                sx[l] <= '0;
                sy[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LAYERS; l++) begin
                if (host.scroll_we && 32'(host.host_layer) == l) begin
                    sx[l] <= host.scroll_x_din;
                    sy[l] <= host.scroll_y_din;
                end
            end
        end
    end
`endif

    // per layer: scrolled coordinates, then tile-map read with fine bits alongside, then tile-set read
    always_ff @(posedge VGA_CLK) begin
        for (int l = 0; l < LAYERS; l++) begin
            ex[l]   <= XW'(hcount) + sx[l];
            ey[l]   <= YW'(vcount) + sy[l];
            tile[l] <= tm_mem[l][{ey[l][YW-1:TILE_BITS], ex[l][XW-1:TILE_BITS]}];
            fine[l] <= {ey[l][TILE_BITS-1:0], ex[l][TILE_BITS-1:0]};
            pix[l]  <= ts_mem[l][{tile[l], fine[l]}];
        end
    end

    // highest enabled opaque layer wins; an all-transparent stack falls back to index 0
    always_comb begin
        cidx = '0;
        for (int l = 0; l < LAYERS; l++) cidx = (layer_enable[l] && pix[l] != '0) ? pix[l] : cidx;
    end

    // palette lookup and sync delay line; vld keeps stale datapath contents off the pins after reset
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RESET) begin
            vld  <= '0;
            hs_d <= '1;
            vs_d <= '1;
            bl_d <= '0;
            rgb  <= '0;
        end else begin
            vld  <= {vld[1:0], 1'b1};
            hs_d <= {hs_d[2:0], hs_in};
            vs_d <= {vs_d[2:0], vs_in};
            bl_d <= {bl_d[2:0], blank_n_in};
            rgb  <= vld[2] ? pal[cidx] : '0;
        end
    end

    assign {VGA_B, VGA_G, VGA_R} = rgb;
    assign VGA_HS      = hs_d[3];
    assign VGA_VS      = vs_d[3];
    assign VGA_BLANK_n = bl_d[3];
endmodule

// File: doc/tile_layers.md
# tile_layers

Parametrised multi-layer successor to the single-layer tile renderer: composites `LAYERS` independently scrolled tile planes (X and Y scroll, wrap-around) into one palette-indexed pixel stream for the VGA output. It sits between the VGA counters and the DAC pins. Each layer has its own tile map and tile set; all layers share one palette. Colour index 0 is transparent on every layer except layer 0. A host port on the same clock loads all memories and scroll registers.

## Interface
- `LAYERS`, 2, number of tile planes (1..4); layer 0 is the bottom layer.
- `TILE_BITS`, 5, log2 of tile edge in pixels (32×32 tiles).
- `MAP_COLS_BITS`, 6, log2 of tile-map columns.
- `MAP_ROWS_BITS`, 4, log2 of tile-map rows.
- `TILES_BITS`, 4, log2 of tile patterns per tile set; this is also the tile-map data width.
- `COLOR_BITS`, 4, colour-index width; the palette has 2^COLOR_BITS entries of 24 bits.
- Derived widths:
  - XW = MAP_COLS_BITS + TILE_BITS
  - YW = MAP_ROWS_BITS + TILE_BITS
  - TMA = MAP_ROWS_BITS + MAP_COLS_BITS
  - TSA = TILES_BITS + 2·TILE_BITS
  - LW = max(1, clog2(LAYERS))

Ports:
- `VGA_CLK` in 1: the only clock. Everything, including the host port, is synchronous to it.
- `VGA_RESET` in 1: reset, synchronous, active-high.
- `hcount` in 10: current pixel x (0..639 when active), from the counters.
- `vcount` in 10: current pixel y.
- `blank_n_in`, `hs_in`, `vs_in` in 1 each: timing from the counters; syncs are active-low.
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: pixel colour.
- `VGA_HS`, `VGA_VS`, `VGA_BLANK_n` out 1 each: timing signals delayed to match the pixel.
- `host_layer` in LW: selects the layer for tile-map, tile-set and scroll accesses.
- `tm_address` in TMA; `tm_we` in 1; `tm_din` in TILES_BITS; `tm_dout` out TILES_BITS.
- `ts_address` in TSA; `ts_we` in 1; `ts_din` in COLOR_BITS; `ts_dout` out COLOR_BITS.
- `palette_address` in COLOR_BITS; `palette_we` in 1; `palette_din` in 24 ({B,G,R}); `palette_dout` out 24.
- `scroll_we` in 1; `scroll_x_din` in XW; `scroll_y_din` in YW.
- `layer_enable` in LAYERS: per-layer enable; sampled live.

## Operation
- Per layer L, from the committed scroll values sx/sy:
  - ex = (hcount + sx) mod 2^XW
  - ey = (vcount + sy) mod 2^YW
  - Wrap-around is natural truncation, with no clamp.
- Tile-map address = {ey[YW-1:TILE_BITS], ex[XW-1:TILE_BITS]}.
- Tile-set address = {tile, ey[TILE_BITS-1:0], ex[TILE_BITS-1:0]}. The fine bits are pipelined alongside the map read.
- Compositing picks the highest enabled layer with a non-zero index. If no such layer exists, the result is layer 0's index when layer 0 is enabled, otherwise 0.
- The composite index drives the palette lookup.
- Host writes:
  - A write lands in the selected layer's memory at the clock edge.
  - Reads are registered: `*_dout` reflects the address and layer of the previous cycle.
  - A same-cycle write plus read of one address returns the old data.
- Host accesses never stall or corrupt the display port, because each memory is dual-port.
- `scroll_we` writes {x,y} for `host_layer`. Commit timing is set by the configuration macro (see Configuration).
- `host_layer` ≥ LAYERS: writes are ignored and reads return 0.

## Timing
- Display pipeline latency is 4 cycles, counter inputs to outputs:
  - address registration
  - tile-map read
  - tile-set read + compositing register
  - palette read
- `VGA_HS`, `VGA_VS` and `VGA_BLANK_n` are delayed by exactly 4 cycles so they stay aligned with the RGB for the same pixel.
- Reset values:
  - RGB 0
  - `VGA_HS` = `VGA_VS` = 1
  - `VGA_BLANK_n` = 0
  - all sync pipeline stages flushed to those values
  - committed and shadow scroll 0
  - `*_dout` 0
  - memory contents unchanged
- Reset asserted mid-frame: outputs take their reset values on the next edge. After release, valid pixels appear 4 cycles after the first sampled input.
- Vsync commit point: the first cycle with `vs_in` = 0 whose previous sampled value was 1. This falling-edge detector resets to "previous = 1".

## Configuration
- `TILE_LAYERS_VSYNC_LATCH_EN` defined:
  - `scroll_we` loads a per-layer shadow register.
  - All shadows copy to the committed registers together at the vsync commit point, so scroll changes are tear-free.
  - A `scroll_we` in the same cycle as the commit lands in the shadow only, and is committed at the next frame.
- Undefined:
  - `scroll_we` writes the committed register directly; the new value is used for addresses from the next cycle.
  - There are no shadow registers and no edge detector.

## Test plan
- Reset with `hs_in`/`vs_in` = 0 → `VGA_HS` = `VGA_VS` = 1, `VGA_BLANK_n` = 0, RGB 0 for all 4 post-reset cycles.
- LAYERS = 2, layer 0 all tile 1 with pixels = index 3, layer 1 all index 0, palette[3] = 24'h0000FF → R = 8'hFF, G = B = 0 exactly 4 cycles after `blank_n_in` rises.
- Layer 1 tile (0,0) pixel (5,5) = index 7, palette[7] = 24'h00FF00 → at hcount = 5, vcount = 5 the output is G = 8'hFF. Clearing `layer_enable[1]` shows layer 0's colour instead.
- Layer 0 scroll_x = 2^XW − 1, hcount = 0 → fetches map column 2^MAP_COLS_BITS − 1, fine x = 31 (wrap). scroll_y = 16, vcount = 500 → ey = 516 mod 512 = 4.
- With the macro defined, write scroll_x = 40 mid-frame → output unchanged until the `vs_in` falling edge, then shifted by 40 pixels. Without the macro → shifted from the next cycle.
- Host writes `tm_address` = 10 with value 5 on layer 1, then reads it → `tm_dout` = 5 one cycle after the read. A write during active video produces no disturbance to the pixel stream other than the intended content change.
